// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller: state encoding, opcode/funct
// constants, ALU operation codes and the bundled control word.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_CMP = 3'b100;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic       pcen;
        logic       illegal;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/mc_control_if.sv
// Bundle of the instruction fields and datapath controls exchanged between the
// instruction/ALU side (master) and the controller (slave).
interface mc_control_if #(
    parameter int OP_W = 6
);
    logic [OP_W-1:0] opcode;
    logic [OP_W-1:0] funct;
    logic            zero;
    logic            iord;
    logic            memwrite;
    logic            irwrite;
    logic            regdst;
    logic            memtoreg;
    logic            regwrite;
    logic            alusrca;
    logic            pcen;
    logic            illegal;
    logic [1:0]      alusrcb;
    logic [1:0]      pcsrc;
    logic [2:0]      aluop;
    logic [3:0]      state;

    modport master (
        output opcode, funct, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               pcen, illegal, alusrcb, pcsrc, aluop, state
    );

    modport slave (
        input  opcode, funct, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               pcen, illegal, alusrcb, pcsrc, aluop, state
    );
endinterface

// File: rtl/alu_decoder.sv
// R-type funct to ALU operation map; unknown functs fall back to add and flag illegal.
module alu_decoder
    import mc_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] funct,
    output logic [2:0]      aluop,
    output logic            illegal
);

    always_comb begin
        aluop   = ALU_ADD;
        illegal = 1'b0;
        case (funct)
            OP_W'(FN_ADD): aluop = ALU_ADD;
            OP_W'(FN_SUB): aluop = ALU_SUB;
            OP_W'(FN_AND): aluop = ALU_AND;
            OP_W'(FN_OR):  aluop = ALU_OR;
            OP_W'(FN_SLT): aluop = ALU_SLT;
            default:       illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle datapath controller: 12-state FSM with state-decoded controls, plus
// zero-qualified pcen in BRANCH and funct-decoded aluop in EXECUTE.
module mc_control
    import mc_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic [OP_W-1:0] funct,
    input  logic            zero,
    output logic            iord,
    output logic            memwrite,
    output logic            irwrite,
    output logic            regdst,
    output logic            memtoreg,
    output logic            regwrite,
    output logic            alusrca,
    output logic            pcen,
    output logic            illegal,
    output logic [1:0]      alusrcb,
    output logic [1:0]      pcsrc,
    output logic [2:0]      aluop,
    output logic [3:0]      state
);

    state_t     state_q;
    state_t     state_d;
    ctrl_t      ctrl;
    logic [2:0] fn_aluop;
    logic       fn_illegal;
    logic       is_lw, is_sw, is_r, is_beq, is_bne, is_addi, is_j, op_known;

    assign is_lw    = (opcode == OP_W'(OP_LW));
    assign is_sw    = (opcode == OP_W'(OP_SW));
    assign is_r     = (opcode == OP_W'(OP_RTYPE));
    assign is_beq   = (opcode == OP_W'(OP_BEQ));
    assign is_bne   = (opcode == OP_W'(OP_BNE));
    assign is_addi  = (opcode == OP_W'(OP_ADDI));
    assign is_j     = (opcode == OP_W'(OP_J));
    assign op_known = is_lw | is_sw | is_r | is_beq | is_bne | is_addi | is_j;

    alu_decoder #(.OP_W(OP_W)) u_alu_decoder (
        .funct   (funct),
        .aluop   (fn_aluop),
        .illegal (fn_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (is_lw || is_sw)        state_d = S_MEMADR;
                else if (is_r)             state_d = S_EXECUTE;
                else if (is_beq || is_bne) state_d = S_BRANCH;
                else if (is_addi)          state_d = S_ADDIEX;
                else if (is_j)             state_d = S_JUMP;
                else                       state_d = S_FETCH;
            end
            S_MEMADR:  state_d = is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Reset masks every control so an aborted instruction cannot write anything.
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.irwrite = 1'b1;
                ctrl.pcen    = 1'b1;
                ctrl.alusrcb = 2'b01;
                ctrl.aluop   = ALU_ADD;
            end
            S_DECODE: begin
                ctrl.alusrcb = 2'b11;
                ctrl.aluop   = ALU_ADD;
                ctrl.illegal = ~op_known;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
                ctrl.aluop   = ALU_ADD;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = fn_aluop;
                ctrl.illegal = fn_illegal;
            end
            S_ALUWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_ADDIWB: ctrl.regwrite = 1'b1;
            S_BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALU_CMP;
                ctrl.pcsrc   = 2'b01;
                ctrl.pcen    = (is_beq & zero) | (is_bne & ~zero);
            end
            S_JUMP: begin
                ctrl.pcsrc = 2'b10;
                ctrl.pcen  = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            ctrl = '0;
        end
    end

    assign iord     = ctrl.iord;
    assign memwrite = ctrl.memwrite;
    assign irwrite  = ctrl.irwrite;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign regwrite = ctrl.regwrite;
    assign alusrca  = ctrl.alusrca;
    assign pcen     = ctrl.pcen;
    assign illegal  = ctrl.illegal;
    assign alusrcb  = ctrl.alusrcb;
    assign pcsrc    = ctrl.pcsrc;
    assign aluop    = ctrl.aluop;
    assign state    = state_q;

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL expose parameter OP_W, default 6: opcode and funct field width in bits.
REQ-002 Port clk, input, 1: the single clock; all state changes occur on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port opcode, input, OP_W: instruction bits [31:26], sampled from the instruction register.
REQ-005 Port funct, input, OP_W: instruction bits [5:0].
REQ-006 Port zero, input, 1: ALU compare flag; valid only while aluop=100.
REQ-007 Outputs, 1 bit each: iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal.
REQ-008 Outputs alusrcb[1:0], pcsrc[1:0] and aluop[2:0]; aluop drives the ALU operation input directly.
REQ-009 Output state[3:0]: current FSM state, for debug.

Function
REQ-010 The block SHALL sequence the multi-cycle datapath with a 12-state FSM: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-011 Transitions: FETCH->DECODE; DECODE->MEMADR for lw/sw, EXECUTE for R-type, BRANCH for beq/bne, ADDIEX for addi, JUMP for j, FETCH otherwise.
REQ-012 Further transitions: MEMADR->MEMRD for lw, MEMWR for sw; MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB; MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP each ->FETCH.
REQ-013 Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
REQ-014 Cycles per instruction: lw 5; sw, R-type and addi 4; beq, bne and j 3; unsupported opcode 2.
REQ-015 Every output not listed for a state SHALL be 0.
REQ-016 FETCH: irwrite=1, pcen=1, alusrcb=01, aluop=010, iord=0, pcsrc=00.
REQ-017 DECODE: alusrca=0, alusrcb=11, aluop=010 (precomputes the branch target).
REQ-018 MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=010.
REQ-019 MEMRD: iord=1.
REQ-020 MEMWB: memtoreg=1, regwrite=1.
REQ-021 MEMWR: iord=1, memwrite=1.
REQ-022 EXECUTE: alusrca=1, alusrcb=00, aluop from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
REQ-023 ALUWB: regdst=1, regwrite=1. ADDIWB: regwrite=1.
REQ-024 BRANCH: alusrca=1, alusrcb=00, aluop=100, pcsrc=01; pcen=zero for beq and pcen=~zero for bne, combinationally in the same cycle.
REQ-025 JUMP: pcsrc=10, pcen=1.
REQ-026 An unsupported opcode in DECODE or unsupported funct in EXECUTE SHALL assert illegal for exactly that cycle.
REQ-027 An unsupported funct SHALL still complete through ALUWB using aluop=010.
REQ-028 Outputs SHALL be decoded from the registered state, except pcen in BRANCH and aluop in EXECUTE, which also depend on the current inputs.

Reset
REQ-029 Asserting reset SHALL force state to FETCH immediately, without waiting for a clock edge.
REQ-030 While reset is high, all outputs other than state SHALL be 0.
REQ-031 Reset asserted mid-instruction SHALL abort that instruction with no further register or memory write.
REQ-032 The first rising edge after reset deassertion SHALL execute FETCH.

Structure
REQ-033 Shared package mc_pkg SHALL hold the state encoding (4-bit), the opcode and funct constants, and the ALU operation codes 010, 110, 000, 001, 111 and 100.
REQ-034 The funct-to-aluop mapping SHALL be a combinational sub-module alu_decoder (funct in; aluop and illegal out); the FSM stays in mc_control.

Verification
REQ-035 Reset, then lw (100011): states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 clocks, with regwrite=1 and memtoreg=1 only in cycle 5.
REQ-036 R-type, funct 100010: EXECUTE drives aluop=110; ALUWB drives regdst=1 and regwrite=1; the next state is FETCH.
REQ-037 beq with zero=1 gives pcen=1 and pcsrc=01 in BRANCH; repeating with zero=0 gives pcen=0; bne gives the inverse results.
REQ-038 Opcode 111111: illegal=1 in DECODE, no write enables asserted, and FETCH on the next clock.
REQ-039 sw with reset asserted during MEMADR: state is FETCH before the next edge, memwrite is never 1, and fetch resumes after release.
REQ-040 j (000010): JUMP asserts pcen=1 and pcsrc=10 for one cycle and the instruction totals 3 cycles.
